// File: rtl/key_event_decoder_if.sv
// Key level in, gesture events out: the link between key_debounce and led_ctl.
// The decoder side is the master (it produces the events).
interface key_event_decoder_if;
   logic key_down;
   logic click_pulse;
   logic dbl_pulse;
   logic long_pulse;
   logic rpt_pulse;
   logic busy;

   modport master (
      input  key_down,
      output click_pulse, dbl_pulse, long_pulse, rpt_pulse, busy
   );

   modport slave (
      output key_down,
      input  click_pulse, dbl_pulse, long_pulse, rpt_pulse, busy
   );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies a debounced key level into one-cycle click, double-click,
// long-press and auto-repeat events; all outputs are registered.
module key_event_decoder #(
   parameter int LONG_CNT    = 50_000_000,
   parameter int DBL_GAP_CNT = 15_000_000,
   parameter int REPEAT_CNT  = 10_000_000,
   parameter int CNT_W       = 26
) (
   input  logic                sclk,
   input  logic                s_rst,
   key_event_decoder_if.master kif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      HOLD   = 3'd2,
      WAIT2  = 3'd3,
      PRESS2 = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CNT - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CNT - 1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             key_d_r;
   logic             click_r;
   logic             dbl_r;
   logic             long_r;
   logic             rpt_r;
   logic             busy_r;
   logic             rise_s;

   assign rise_s          = kif.key_down & ~key_d_r;
   assign kif.click_pulse = click_r;
   assign kif.dbl_pulse   = dbl_r;
   assign kif.long_pulse  = long_r;
   assign kif.rpt_pulse   = rpt_r;
   assign kif.busy        = busy_r;

   // Gesture FSM: state, shared counter, edge-detect copy and event outputs.
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         key_d_r <= 1'b1;   // a key held through reset must be released first
         click_r <= 1'b0;
         dbl_r   <= 1'b0;
         long_r  <= 1'b0;
         rpt_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         key_d_r <= kif.key_down;
         click_r <= 1'b0;
         dbl_r   <= 1'b0;
         long_r  <= 1'b0;
         rpt_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (rise_s) begin
                  state_r <= PRESS1;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            PRESS1: begin
               busy_r <= 1'b1;
               // release is tested first so it beats the long-press terminal count
               if (!kif.key_down) begin
                  state_r <= WAIT2;
                  cnt_r   <= {CNT_W{1'b0}};
               end else if (cnt_r == LONG_LAST) begin
                  long_r  <= 1'b1;
                  state_r <= HOLD;
                  cnt_r   <= {CNT_W{1'b0}};
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
               end
            end
            HOLD: begin
               if (!kif.key_down) begin
                  state_r <= IDLE;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b0;
               end else if (cnt_r == RPT_LAST) begin
                  rpt_r   <= 1'b1;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b1;
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
                  busy_r  <= 1'b1;
               end
            end
            WAIT2: begin
               if (kif.key_down) begin
                  state_r <= PRESS2;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b1;
               end else if (cnt_r == GAP_LAST) begin
                  click_r <= 1'b1;
                  state_r <= IDLE;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
                  busy_r  <= 1'b1;
               end
            end
            PRESS2: begin
               if (!kif.key_down) begin
                  dbl_r   <= 1'b1;
                  state_r <= IDLE;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b0;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CNT_W{1'b0}};
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: gesture scenarios with hand-computed
// pulse counts and edge numbers, using short timing parameters.
module tb_key_event_decoder;

   logic sclk;
   logic s_rst;
   int   checks;
   int   errors;
   int   cyc;
   int   e0;

   int n_click, t_click;
   int n_dbl, t_dbl;
   int n_long, t_long;
   int n_rpt, t_rpt_first, t_rpt_last;
   int n_multi, n_busy, t_busy_last;

   key_event_decoder_if kif ();

   key_event_decoder #(
      .LONG_CNT    (20),
      .DBL_GAP_CNT (10),
      .REPEAT_CNT  (5),
      .CNT_W       (8)
   ) dut (
      .sclk  (sclk),
      .s_rst (s_rst),
      .kif   (kif.master)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      n_click = 0; t_click = -1;
      n_dbl = 0;   t_dbl = -1;
      n_long = 0;  t_long = -1;
      n_rpt = 0;   t_rpt_first = -1; t_rpt_last = -1;
      n_multi = 0; n_busy = 0; t_busy_last = -1;
   endtask

   // Advance one edge (edge number = cyc) and record what the outputs show.
   task automatic tick();
      @(posedge sclk);
      cyc++;
      #1;
      if (kif.click_pulse) begin n_click++; t_click = cyc; end
      if (kif.dbl_pulse)   begin n_dbl++;   t_dbl = cyc;   end
      if (kif.long_pulse)  begin n_long++;  t_long = cyc;  end
      if (kif.rpt_pulse) begin
         if (n_rpt == 0) t_rpt_first = cyc;
         n_rpt++;
         t_rpt_last = cyc;
      end
      if ((int'(kif.click_pulse) + int'(kif.dbl_pulse) +
           int'(kif.long_pulse) + int'(kif.rpt_pulse)) > 1) n_multi++;
      if (kif.busy) begin n_busy++; t_busy_last = cyc; end
   endtask

   task automatic drive(input logic k, input int n);
      kif.key_down = k;
      repeat (n) tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_click"}, int'(kif.click_pulse), 0);
      check_val({tag, "_dbl"},   int'(kif.dbl_pulse),   0);
      check_val({tag, "_long"},  int'(kif.long_pulse),  0);
      check_val({tag, "_rpt"},   int'(kif.rpt_pulse),   0);
      check_val({tag, "_busy"},  int'(kif.busy),        0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      clear_stats();
      s_rst        = 1'b1;
      kif.key_down = 1'b0;
      repeat (2) tick();
      check_outputs_zero("reset");
      s_rst = 1'b0;
      drive(1'b0, 2);

      // single click: press 5, release; click 10 edges after release edge E0+5
      clear_stats();
      e0 = cyc + 1;
      drive(1'b1, 5);
      drive(1'b0, 30);
      check_val("sc_click_n", n_click, 1);
      check_val("sc_click_t", t_click - e0, 15);
      check_val("sc_other_n", n_dbl + n_long + n_rpt, 0);
      check_val("sc_busy_last", t_busy_last - e0, 14);
      check_val("sc_busy_n", n_busy, 15);

      // double click: press 5, release 4, press 3, release at E0+12
      clear_stats();
      e0 = cyc + 1;
      drive(1'b1, 5);
      drive(1'b0, 4);
      drive(1'b1, 3);
      drive(1'b0, 30);
      check_val("dc_dbl_n", n_dbl, 1);
      check_val("dc_dbl_t", t_dbl - e0, 12);
      check_val("dc_click_n", n_click, 0);
      check_val("dc_busy_last", t_busy_last - e0, 11);

      // long press + repeat: key high on edges E0..E0+40, released at E0+41
      clear_stats();
      e0 = cyc + 1;
      drive(1'b1, 41);
      drive(1'b0, 30);
      check_val("lr_long_n", n_long, 1);
      check_val("lr_long_t", t_long - e0, 20);
      check_val("lr_rpt_n", n_rpt, 4);
      check_val("lr_rpt_first", t_rpt_first - e0, 25);
      check_val("lr_rpt_last", t_rpt_last - e0, 40);
      check_val("lr_click_dbl_n", n_click + n_dbl, 0);
      check_val("lr_multi", n_multi, 0);

      // release exactly on the long-press terminal edge E0+20
      clear_stats();
      e0 = cyc + 1;
      drive(1'b1, 20);
      drive(1'b0, 30);
      check_val("rl_long_n", n_long, 0);
      check_val("rl_click_n", n_click, 1);
      check_val("rl_click_t", t_click - e0, 30);

      // re-press exactly on gap count 9 (release edge R=E0+3, press at R+10)
      clear_stats();
      e0 = cyc + 1;
      drive(1'b1, 3);
      drive(1'b0, 10);
      drive(1'b1, 3);
      drive(1'b0, 30);
      check_val("rg_dbl_n", n_dbl, 1);
      check_val("rg_dbl_t", t_dbl - e0, 16);
      check_val("rg_click_n", n_click, 0);

      // reset while waiting for a second press
      drive(1'b1, 3);
      drive(1'b0, 4);
      check_val("rw_busy_before", int'(kif.busy), 1);
      s_rst = 1'b1;
      tick();
      check_outputs_zero("rw");
      s_rst = 1'b0;
      clear_stats();
      drive(1'b0, 30);
      check_val("rw_click_n", n_click, 0);
      check_val("rw_busy_n", n_busy, 0);

      // key held across reset: silent until released and pressed again
      kif.key_down = 1'b1;
      s_rst        = 1'b1;
      repeat (2) tick();
      s_rst = 1'b0;
      clear_stats();
      drive(1'b1, 50);
      check_val("hr_pulses_n", n_click + n_dbl + n_long + n_rpt, 0);
      check_val("hr_busy_n", n_busy, 0);
      drive(1'b0, 3);
      clear_stats();
      e0 = cyc + 1;
      drive(1'b1, 5);
      drive(1'b0, 30);
      check_val("hr_click_n", n_click, 1);
      check_val("hr_click_t", t_click - e0, 15);
      check_val("hr_multi", n_multi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
